dog_extrema_detect: RTL and testbench

- Parametrised successor to the single-scale DoG maximum comparator in Get_Feature.
- Takes NUM_DOG DoG layers as one raster pixel stream and builds a 3x3 window per layer. Every interior layer is a detection scale; each pixel centre is tested for strict maximum and strict minimum against its 26 neighbours.
- Keypoint records go to a small output FIFO with a valid/ready handshake, read by the descriptor stage.

---
 rtl/dog_extrema_detect_pkg.sv | 36 +++
 rtl/dog_extrema_detect_window3x3.sv | 59 +++++
 rtl/dog_extrema_detect.sv | 191 +++++++++++++++++++
 tb/tb_dog_extrema_detect.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dog_extrema_detect_pkg.sv
// Shared constants and helpers for the DoG extrema detector.
//   - scale count derived from the number of DoG layers in the stream
//   - keypoint record width and field offsets (LSB first: min mask,
//     max mask, centre row, centre column)
//   - 3x3 window tap numbering: tap = row*3 + col, row 0 is the oldest
//     line, col 0 is the oldest column, so the centre is tap 4
package dog_extrema_detect_pkg;

  localparam int WIN_TAPS   = 9;
  localparam int CENTRE_TAP = 4;

  function automatic int scales_of(input int num_dog);
    return num_dog - 2;
  endfunction

  function automatic int rec_w(input int cw, input int scales);
    return 2 * cw + 2 * scales;
  endfunction

  function automatic int off_min(input int scales);
    return 0 * scales;
  endfunction

  function automatic int off_max(input int scales);
    return scales;
  endfunction

  function automatic int off_y(input int scales);
    return 2 * scales;
  endfunction

  function automatic int off_x(input int cw, input int scales);
    return 2 * scales + cw;
  endfunction

endpackage

// File: rtl/dog_extrema_detect_window3x3.sv
// One DoG layer's 3x3 neighbourhood builder.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   valid_in      pixel strobe; everything advances only on it
//   col           column of the incoming pixel (line-buffer address)
//   din           incoming sample
//   win           9 samples, tap k at [k*DW +: DW], k = row*3 + col,
//                 row 0 = two lines up, col 0 = two pixels left
// Line buffers are plain storage with no reset; whether the window holds
// real data is decided by the position counters in the parent.
module dog_window3x3
  import dog_extrema_detect_pkg::*;
#(
  parameter int WIDE = 256,
  parameter int DW   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_in,
  input  logic [$clog2(WIDE)-1:0]    col,
  input  logic [DW-1:0]              din,
  output logic [WIN_TAPS*DW-1:0]     win
);

  logic [DW-1:0] lb0 [WIDE];  // previous line
  logic [DW-1:0] lb1 [WIDE];  // line before that
  logic [DW-1:0] w [3][3];

  always_ff @(posedge clk) begin
    if (valid_in) begin
      lb0[col] <= din;
      lb1[col] <= lb0[col];
    end
  end

  // New rightmost column is {two lines up, one line up, current line}.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w[r][c] <= '0;
    end else if (valid_in) begin
      for (int r = 0; r < 3; r++) begin
        w[r][0] <= w[r][1];
        w[r][1] <= w[r][2];
      end
      w[0][2] <= lb1[col];
      w[1][2] <= lb0[col];
      w[2][2] <= din;
    end
  end

  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar c = 0; c < 3; c++) begin : g_col
      assign win[(r*3+c)*DW +: DW] = w[r][c];
    end
  end

endmodule

// File: rtl/dog_extrema_detect.sv
// Multi-scale DoG extrema detector.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   valid_in        pixel strobe (never back-pressured)
//   sof_in          first pixel of frame, qualified by valid_in
//   data_in         NUM_DOG signed samples, layer 0 in the LSBs
//   thr             unsigned contrast threshold
//   kp_valid/ready  keypoint FIFO head handshake
//   kp_x, kp_y      centre column/row of the head record
//   kp_max, kp_min  per-scale extremum flags of the head record
//   kp_count        records written this frame, saturating
//   overflow        sticky: a record was dropped on a full FIFO
//   frame_done      one-cycle pulse after the last pixel's decision
// Handshake: a pop happens on a cycle where kp_valid && kp_ready; the head
// is first-word-fall-through and holds steady while kp_valid && !kp_ready.
module dog_extrema_detect
  import dog_extrema_detect_pkg::*;
#(
  parameter int WIDE       = 256,
  parameter int HIGN       = 256,
  parameter int DW         = 8,
  parameter int NUM_DOG    = 3,
  parameter int MARGIN     = 18,
  parameter int CW         = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_DW     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic                  sof_in,
  input  logic [NUM_DOG*DW-1:0] data_in,
  input  logic [DW-2:0]         thr,
  output logic                  kp_valid,
  input  logic                  kp_ready,
  output logic [CW-1:0]         kp_x,
  output logic [CW-1:0]         kp_y,
  output logic [NUM_DOG-3:0]    kp_max,
  output logic [NUM_DOG-3:0]    kp_min,
  output logic [CNT_DW-1:0]     kp_count,
  output logic                  overflow,
  output logic                  frame_done
);

  localparam int SCALES = scales_of(NUM_DOG);
  localparam int RW     = rec_w(CW, SCALES);
  localparam int AW     = $clog2(WIDE);
  localparam int PW     = $clog2(FIFO_DEPTH);

  // ---------------- position counters (point at the next pixel)
  logic          sof_hit;
  logic [CW-1:0] x_cnt, y_cnt, px, py, cx, cy;
  logic          in_gate;

  assign sof_hit = valid_in && sof_in;
  assign px      = sof_hit ? '0 : x_cnt;
  assign py      = sof_hit ? '0 : y_cnt;
  assign cx      = px - CW'(1);
  assign cy      = py - CW'(1);
  assign in_gate = (px >= CW'(2)) && (py >= CW'(2)) &&
                   (cx >= CW'(MARGIN)) && (cx <= CW'(WIDE-1-MARGIN)) &&
                   (cy >= CW'(MARGIN)) && (cy <= CW'(HIGN-1-MARGIN));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (valid_in) begin
      x_cnt <= (px == CW'(WIDE-1)) ? '0 : px + CW'(1);
      if (px == CW'(WIDE-1))
        y_cnt <= (py == CW'(HIGN-1)) ? '0 : py + CW'(1);
      else
        y_cnt <= py;
    end
  end

  // ---------------- per-layer windows
  logic [WIN_TAPS*DW-1:0] win [NUM_DOG];

  for (genvar l = 0; l < NUM_DOG; l++) begin : g_layer
    dog_window3x3 #(.WIDE(WIDE), .DW(DW)) u_win (
      .clk      (clk),
      .rst      (rst),
      .valid_in (valid_in),
      .col      (px[AW-1:0]),
      .din      (data_in[l*DW +: DW]),
      .win      (win[l])
    );
  end

  // ---------------- candidate stage, aligned with the updated window
  logic          st_cand, st_last;
  logic [CW-1:0] st_cx, st_cy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_cand <= 1'b0;
      st_last <= 1'b0;
      st_cx   <= '0;
      st_cy   <= '0;
    end else begin
      st_cand <= valid_in && in_gate;
      st_last <= valid_in && (px == CW'(WIDE-1)) && (py == CW'(HIGN-1));
      if (valid_in) begin
        st_cx <= cx;
        st_cy <= cy;
      end
    end
  end

  // ---------------- 26-neighbour strict extremum test, DW+1 signed
  function automatic logic signed [DW:0] sx(input logic [DW-1:0] v);
    return {v[DW-1], v};
  endfunction

  logic [SCALES-1:0]  dec_max, dec_min;
  logic signed [DW:0] c_e, n_e, thr_p, thr_n;

  assign thr_p = {2'b00, thr};
  assign thr_n = -thr_p;

  always_comb begin
    dec_max = '0;
    dec_min = '0;
    c_e     = '0;
    n_e     = '0;
    for (int s = 0; s < SCALES; s++) begin
      c_e        = sx(win[s+1][CENTRE_TAP*DW +: DW]);
      dec_max[s] = c_e > thr_p;
      dec_min[s] = c_e < thr_n;
      for (int l = 0; l < 3; l++) begin
        for (int k = 0; k < WIN_TAPS; k++) begin
          if (!(l == 1 && k == CENTRE_TAP)) begin
            n_e = sx(win[s+l][k*DW +: DW]);
            if (!(c_e > n_e)) dec_max[s] = 1'b0;
            if (!(c_e < n_e)) dec_min[s] = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- keypoint FIFO (extra pointer bit separates full/empty)
  logic [RW-1:0] mem [FIFO_DEPTH];
  logic [PW:0]   wr_ptr, rd_ptr;
  logic          full, empty, wr_req, wr_ok, pop;
  logic [RW-1:0] head;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign wr_req = st_cand && ((|dec_max) || (|dec_min));
  assign pop    = !empty && kp_ready;
  assign wr_ok  = wr_req && (!full || pop);  // a same-cycle pop frees the slot
  assign head   = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_ptr[PW-1:0]] <= {st_cx, st_cy, dec_max, dec_min};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      kp_count   <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      frame_done <= st_last;
      if (sof_hit) begin
        kp_count <= '0;
        overflow <= 1'b0;
      end else begin
        if (wr_ok && (kp_count != {CNT_DW{1'b1}}))
          kp_count <= kp_count + 1'b1;
        if (wr_req && !wr_ok)
          overflow <= 1'b1;
      end
    end
  end

  // Unwritten FIFO storage is never exposed: fields read 0 while empty.
  assign kp_valid = !empty;
  assign kp_x     = kp_valid ? head[off_x(CW, SCALES) +: CW]   : '0;
  assign kp_y     = kp_valid ? head[off_y(SCALES) +: CW]       : '0;
  assign kp_max   = kp_valid ? head[off_max(SCALES) +: SCALES] : '0;
  assign kp_min   = kp_valid ? head[off_min(SCALES) +: SCALES] : '0;

endmodule

// File: tb/tb_dog_extrema_detect.sv
module tb_dog_extrema_detect;

  localparam int WIDE = 16, HIGN = 16, DW = 8, NUM_DOG = 3, MARGIN = 2;
  localparam int CW = 16, FIFO_DEPTH = 4, CNT_DW = 16;
  localparam int RW = 2 * CW + 2;

  // ---------------- clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                  valid_in = 1'b0, sof_in = 1'b0, kp_ready = 1'b0;
  logic [NUM_DOG*DW-1:0] data_in = '0;
  logic [DW-2:0]         thr = '0;
  logic                  kp_valid, overflow, frame_done;
  logic [CW-1:0]         kp_x, kp_y;
  logic [0:0]            kp_max, kp_min;
  logic [CNT_DW-1:0]     kp_count;

  dog_extrema_detect #(
    .WIDE(WIDE), .HIGN(HIGN), .DW(DW), .NUM_DOG(NUM_DOG), .MARGIN(MARGIN),
    .CW(CW), .FIFO_DEPTH(FIFO_DEPTH), .CNT_DW(CNT_DW)
  ) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .sof_in(sof_in),
    .data_in(data_in), .thr(thr), .kp_valid(kp_valid), .kp_ready(kp_ready),
    .kp_x(kp_x), .kp_y(kp_y), .kp_max(kp_max), .kp_min(kp_min),
    .kp_count(kp_count), .overflow(overflow), .frame_done(frame_done)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural model: image memory + record queue
  int            img [NUM_DOG][HIGN][WIDE];
  logic [RW-1:0] exp_q [$];
  int            m_cnt, mx, my;
  logic          m_ovf, m_fd, pend_v, pend_last;
  logic [RW-1:0] pend_rec;

  // {max,min} for the centre of layer 1 at (cx,cy) against its 26 neighbours
  function automatic logic [1:0] classify(input int cx, input int cy, input int t);
    int  c;
    logic mxf, mnf;
    c   = img[1][cy][cx];
    mxf = (c > t);
    mnf = (c < -t);
    for (int l = 0; l < NUM_DOG; l++)
      for (int dy = -1; dy <= 1; dy++)
        for (int dx = -1; dx <= 1; dx++)
          if (!(l == 1 && dx == 0 && dy == 0)) begin
            if (!(c > img[l][cy+dy][cx+dx])) mxf = 1'b0;
            if (!(c < img[l][cy+dy][cx+dx])) mnf = 1'b0;
          end
    return {mxf, mnf};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      m_cnt = 0; m_ovf = 1'b0; m_fd = 1'b0;
      pend_v = 1'b0; pend_last = 1'b0; pend_rec = '0;
      mx = 0; my = 0;
    end else begin
      int px, py;
      logic [1:0] cls;
      if (exp_q.size() > 0 && kp_ready) void'(exp_q.pop_front());
      if (pend_v && pend_rec[1:0] != 2'b00) begin
        if (exp_q.size() < FIFO_DEPTH) begin
          exp_q.push_back(pend_rec);
          if (m_cnt != 65535) m_cnt++;
        end else m_ovf = 1'b1;
      end
      m_fd = pend_last;
      if (valid_in && sof_in) begin m_cnt = 0; m_ovf = 1'b0; end
      pend_v = 1'b0; pend_last = 1'b0;
      if (valid_in) begin
        px = sof_in ? 0 : mx;
        py = sof_in ? 0 : my;
        for (int l = 0; l < NUM_DOG; l++) img[l][py][px] = int'($signed(data_in[l*DW +: DW]));
        if (px >= 2 && py >= 2 && px-1 >= MARGIN && px-1 <= WIDE-1-MARGIN &&
            py-1 >= MARGIN && py-1 <= HIGN-1-MARGIN) begin
          cls      = classify(px-1, py-1, int'(thr));
          pend_v   = 1'b1;
          pend_rec = {CW'(px-1), CW'(py-1), cls};
        end
        pend_last = (px == WIDE-1 && py == HIGN-1);
        mx = (px == WIDE-1) ? 0 : px + 1;
        my = (px == WIDE-1) ? ((py == HIGN-1) ? 0 : py + 1) : py;
      end
    end
  end

  // ---------------- scoreboard / compare process
  int          errors = 0, checks = 0;
  int          fd_seen = 0, fd_cyc = 0, kv_cyc = 0, kv_rises = 0;
  logic        prev_kv = 1'b0;
  logic [31:0] pop_q [$];
  string       lit_name = "";
  longint      lit_act = 0, lit_exp = 0;
  int          lit_seq = 0, lit_done = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [RW-1:0] h;
    if (!rst) begin
      chk("rst_kp_valid", kp_valid, 0);
      chk("rst_kp_x", kp_x, 0);
      chk("rst_kp_y", kp_y, 0);
      chk("rst_kp_flags", {kp_max, kp_min}, 0);
      chk("rst_kp_count", kp_count, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_frame_done", frame_done, 0);
    end else begin
      chk("kp_valid", kp_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        h = exp_q[0];
        chk("kp_x", kp_x, h[RW-1 -: CW]);
        chk("kp_y", kp_y, h[2 +: CW]);
        chk("kp_max", kp_max, h[1]);
        chk("kp_min", kp_min, h[0]);
      end
      chk("kp_count", kp_count, m_cnt);
      chk("overflow", overflow, m_ovf);
      chk("frame_done", frame_done, m_fd);
    end
    if (kp_valid && !prev_kv) begin kv_cyc = cyc; kv_rises++; end
    prev_kv = kp_valid;
    if (frame_done) begin fd_seen++; fd_cyc = cyc; end
    if (kp_valid && kp_ready) pop_q.push_back({kp_x, kp_y});
    if (lit_seq != lit_done) begin
      chk(lit_name, lit_act, lit_exp);
      lit_done = lit_seq;
    end
  end

  // ---------------- driver tasks
  int frm [NUM_DOG][HIGN][WIDE];
  int pix_cyc [HIGN][WIDE];
  int ready_pct = 100;

  task automatic lit(input string name, input longint act, input longint exp);
    lit_name = name; lit_act = act; lit_exp = exp; lit_seq++;
    @(negedge clk); #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
    kp_ready = (int'($urandom_range(0, 99)) < ready_pct);
  endtask

  task automatic clear_frame();
    for (int l = 0; l < NUM_DOG; l++)
      for (int y = 0; y < HIGN; y++)
        for (int x = 0; x < WIDE; x++) frm[l][y][x] = 0;
  endtask

  task automatic random_frame();
    int v;
    for (int l = 0; l < NUM_DOG; l++)
      for (int y = 0; y < HIGN; y++)
        for (int x = 0; x < WIDE; x++) begin
          if ($urandom_range(0, 99) < 4)
            v = ($urandom_range(0, 1) == 1 ? 1 : -1) * int'($urandom_range(20, 100));
          else
            v = int'($urandom_range(0, 16)) - 8;
          frm[l][y][x] = v;
        end
  endtask

  task automatic drive_frame(input int gap_max, input int abort_at);
    for (int y = 0; y < HIGN; y++) begin
      for (int x = 0; x < WIDE; x++) begin
        if (y * WIDE + x == abort_at) begin
          valid_in = 1'b0; sof_in = 1'b0; rst = 1'b0;
          repeat (3) step();
          rst = 1'b1;
          step();
          return;
        end
        valid_in = 1'b1;
        sof_in   = (x == 0 && y == 0);
        for (int l = 0; l < NUM_DOG; l++) data_in[l*DW +: DW] = DW'(frm[l][y][x]);
        pix_cyc[y][x] = cyc;
        step();
        valid_in = 1'b0; sof_in = 1'b0;
        repeat ($urandom_range(0, gap_max)) step();
      end
    end
    repeat (5) step();
  endtask

  task automatic drain();
    ready_pct = 100;
    repeat (FIFO_DEPTH + 3) step();
  endtask

  // ---------------- directed + random scenarios
  initial begin
    int fd0, kv0, n0;
    int ex_x [4];
    int ex_y [4];
    ex_x = '{3, 6, 9, 3};
    ex_y = '{3, 3, 3, 6};

    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();

    // all-zero frame
    clear_frame(); thr = 0; ready_pct = 100;
    fd0 = fd_seen; kv0 = kv_rises;
    drive_frame(0, -1);
    lit("s1_count", kp_count, 0);
    lit("s1_no_record", kv_rises - kv0, 0);
    lit("s1_fd_once", fd_seen - fd0, 1);
    lit("s1_fd_latency", fd_cyc - pix_cyc[15][15], 2);

    // single maximum at (5,7)
    clear_frame(); frm[1][7][5] = 20; thr = 5; ready_pct = 0;
    drive_frame(2, -1);
    lit("s2_latency", kv_cyc - pix_cyc[8][6], 2);
    lit("s2_valid", kp_valid, 1);
    lit("s2_x", kp_x, 5);
    lit("s2_y", kp_y, 7);
    lit("s2_max", kp_max, 1);
    lit("s2_min", kp_min, 0);
    lit("s2_count", kp_count, 1);
    drain();

    // minimum, high threshold, and a tie
    clear_frame(); frm[1][7][5] = -20; thr = 5; ready_pct = 0;
    drive_frame(1, -1);
    lit("s3_min", kp_min, 1);
    lit("s3_max", kp_max, 0);
    lit("s3_min_count", kp_count, 1);
    drain();
    clear_frame(); frm[1][7][5] = 20; thr = 25; ready_pct = 0;
    drive_frame(1, -1);
    lit("s3_thr_count", kp_count, 0);
    clear_frame(); frm[1][7][5] = 20; frm[2][7][6] = 20; thr = 5;
    drive_frame(1, -1);
    lit("s3_tie_count", kp_count, 0);

    // margin gate: x=1 and x=14 outside, (2,2) and (13,13) on the edge
    clear_frame(); thr = 5; ready_pct = 0;
    frm[1][7][1] = 20; frm[1][7][14] = 20; frm[1][2][2] = 20; frm[1][13][13] = 20;
    drive_frame(1, -1);
    lit("s4_count", kp_count, 2);
    lit("s4_x", kp_x, 2);
    lit("s4_y", kp_y, 2);
    drain();

    // overflow with six peaks and a stalled consumer
    clear_frame(); thr = 5; ready_pct = 0;
    frm[1][3][3] = 20; frm[1][3][6] = 20; frm[1][3][9] = 20;
    frm[1][6][3] = 20; frm[1][6][6] = 20; frm[1][6][9] = 20;
    drive_frame(0, -1);
    lit("s5_count", kp_count, 4);
    lit("s5_overflow", overflow, 1);
    lit("s5_head_x", kp_x, 3);
    n0 = pop_q.size();
    ready_pct = 100;
    repeat (8) step();
    lit("s5_pops", pop_q.size() - n0, 4);
    for (int i = 0; i < 4; i++) begin
      lit("s5_pop_x", pop_q[n0+i][31:16], ex_x[i]);
      lit("s5_pop_y", pop_q[n0+i][15:0], ex_y[i]);
    end
    lit("s5_empty", kp_valid, 0);

    // reset mid-frame, then a clean frame
    random_frame(); thr = 3; ready_pct = 50;
    drive_frame(1, 100);
    lit("s6_rst_count", kp_count, 0);
    clear_frame(); frm[1][7][5] = 20; thr = 5; ready_pct = 0;
    drive_frame(1, -1);
    lit("s6_count", kp_count, 1);
    lit("s6_x", kp_x, 5);
    lit("s6_y", kp_y, 7);
    drain();

    // randomized frames against the model
    for (int f = 0; f < 4; f++) begin
      random_frame();
      thr = DW'($urandom_range(0, 10));
      ready_pct = int'($urandom_range(30, 90));
      drive_frame(2, -1);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
